// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared hazard-control definitions for pipeline stage registers
package pipe_stage_reg_pkg;

  localparam int HAZD_CTL_WIDTH = 2;

  typedef logic [HAZD_CTL_WIDTH-1:0] hazd_ctl_t;

  localparam hazd_ctl_t HAZD_CTL_NORMAL = 2'd0;
  localparam hazd_ctl_t HAZD_CTL_NO_OP  = 2'd1;
  localparam hazd_ctl_t HAZD_CTL_RETRY  = 2'd2;
  localparam hazd_ctl_t HAZD_CTL_FLUSH  = 2'd3;

  function automatic logic hazd_is_normal(input hazd_ctl_t ctl);
    return ctl == HAZD_CTL_NORMAL;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating up-counter used for stall statistics
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register; cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline register with hazard control and stall counter
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [HAZD_CTL_WIDTH-1:0] hazard_control,
  input  logic                      ignore_no_op,
  input  logic                      squash,
  input  logic                      up_valid,
  input  logic                      up_no_op,
  input  logic [DATA_W-1:0]         up_data,
  output logic                      up_ready,
  output logic                      dn_valid,
  output logic                      dn_no_op,
  output logic [DATA_W-1:0]         dn_data,
  input  logic                      dn_ready,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                head_no_op_q, head_no_op_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic                skid_no_op_q, skid_no_op_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic is_normal;
  logic accept;
  logic dequeue;
  logic new_no_op;
  logic stall_inc;

  // Handshake qualification; nothing moves unless the hazard unit says NORMAL.
  always_comb begin
    is_normal = hazd_is_normal(hazard_control);
    up_ready  = ~rst & (state_q != ST_TWO) & is_normal;
    dn_valid  = (state_q != ST_EMPTY);
    accept    = up_valid & up_ready;
    dequeue   = dn_valid & dn_ready & is_normal;
    new_no_op = squash | (up_no_op & ~ignore_no_op);
    stall_inc = (hazard_control == HAZD_CTL_RETRY) | (dn_valid & ~dn_ready);
  end

  // Next-state for the head/skid pair; FLUSH overrides everything else.
  always_comb begin
    state_d      = state_q;
    head_no_op_d = head_no_op_q;
    head_data_d  = head_data_q;
    skid_no_op_d = skid_no_op_q;
    skid_data_d  = skid_data_q;
    case (hazard_control)
      HAZD_CTL_FLUSH: begin
        state_d      = ST_EMPTY;
        head_no_op_d = 1'b0;
      end
      HAZD_CTL_NO_OP: begin
        if (state_q != ST_EMPTY) begin
          head_no_op_d = 1'b1;
        end
      end
      HAZD_CTL_RETRY: begin
      end
      default: begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              head_no_op_d = new_no_op;
              head_data_d  = up_data;
              state_d      = ST_ONE;
            end
          end
          ST_ONE: begin
            if (accept && dequeue) begin
              head_no_op_d = new_no_op;
              head_data_d  = up_data;
            end else if (accept) begin
              skid_no_op_d = new_no_op;
              skid_data_d  = up_data;
              state_d      = ST_TWO;
            end else if (dequeue) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (dequeue) begin
              head_no_op_d = skid_no_op_q;
              head_data_d  = skid_data_q;
              state_d      = ST_ONE;
            end
          end
          default: begin
            state_d = ST_EMPTY;
          end
        endcase
      end
    endcase
  end

  // Entry storage; reset drops all held entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      head_no_op_q <= 1'b0;
      head_data_q  <= '0;
      skid_no_op_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_no_op_q <= head_no_op_d;
      head_data_q  <= head_data_d;
      skid_no_op_q <= skid_no_op_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign dn_no_op  = head_no_op_q;
  assign dn_data   = head_data_q;
  assign occupancy = state_q;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [1:0] N = HAZD_CTL_NORMAL;
  localparam logic [1:0] O = HAZD_CTL_NO_OP;
  localparam logic [1:0] R = HAZD_CTL_RETRY;
  localparam logic [1:0] F = HAZD_CTL_FLUSH;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  hc;
  logic        ign, sq, uv, unop, dr;
  logic [63:0] ud;
  logic        ur, dv, dnop;
  logic [63:0] dd;
  logic [1:0]  occ;
  logic [15:0] stall;

  logic [1:0]  s_hc;
  logic        s_uv, s_dr;
  logic [7:0]  s_ud;
  logic        s_ur, s_dv, s_dnop;
  logic [7:0]  s_dd;
  logic [1:0]  s_occ;
  logic [1:0]  s_stall;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .hazard_control(hc), .ignore_no_op(ign), .squash(sq),
    .up_valid(uv), .up_no_op(unop), .up_data(ud), .up_ready(ur),
    .dn_valid(dv), .dn_no_op(dnop), .dn_data(dd), .dn_ready(dr),
    .occupancy(occ), .stall_cnt(stall)
  );

  pipe_stage_reg #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hazard_control(s_hc), .ignore_no_op(1'b0), .squash(1'b0),
    .up_valid(s_uv), .up_no_op(1'b0), .up_data(s_ud), .up_ready(s_ur),
    .dn_valid(s_dv), .dn_no_op(s_dnop), .dn_data(s_dd), .dn_ready(s_dr),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  typedef struct {
    logic [1:0]  hc;
    logic        uv, unop, ign, sq;
    logic [63:0] ud;
    logic        dr;
    logic [1:0]  occ;
    logic        nop, chk_nop;
    logic [63:0] data;
    logic        ur;
    logic [15:0] stall;
  } vec_t;

  typedef struct {
    logic        nop;
    logic [63:0] d;
  } ent_t;

  vec_t tbl[22];
  ent_t mq[$];

  function automatic vec_t mk(logic [1:0] h, logic v, logic un, logic ig, logic s,
                              logic [63:0] d, logic r, logic [1:0] eo, logic en,
                              logic ecn, logic [63:0] ed, logic eur, logic [15:0] es);
    vec_t x;
    x.hc = h; x.uv = v; x.unop = un; x.ign = ig; x.sq = s; x.ud = d; x.dr = r;
    x.occ = eo; x.nop = en; x.chk_nop = ecn; x.data = ed; x.ur = eur; x.stall = es;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] h, input logic v, input logic un, input logic ig,
                       input logic s, input logic [63:0] d, input logic r);
    hc = h; uv = v; unop = un; ign = ig; sq = s; ud = d; dr = r;
  endtask

  initial begin
    int   mcnt;
    int   sz;
    logic acc, deq;
    ent_t e;

    rst = 1'b1;
    drive(N, 0, 0, 0, 0, 64'h0, 1);
    s_hc = N; s_uv = 1'b0; s_dr = 1'b1; s_ud = 8'h0;

    // reset state
    step();
    step();
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_dv", 64'(dv), 64'd0);
    chk("rst_nop", 64'(dnop), 64'd0);
    chk("rst_data", dd, 64'd0);
    chk("rst_ur", 64'(ur), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    // directed table: flow, backpressure, no_op generation, hazard commands
    tbl[0]  = mk(N,1,0,0,0,64'h10,1, 1,0,1,64'h10,1,0);
    tbl[1]  = mk(N,1,0,0,0,64'h20,1, 1,0,1,64'h20,1,0);
    tbl[2]  = mk(N,0,0,0,0,64'h0 ,1, 0,0,0,64'h0 ,1,0);
    tbl[3]  = mk(N,1,0,0,0,64'hA1,0, 1,0,1,64'hA1,1,0);
    tbl[4]  = mk(N,1,0,0,0,64'hB2,0, 2,0,1,64'hA1,0,1);
    tbl[5]  = mk(N,1,0,0,0,64'hC3,0, 2,0,1,64'hA1,0,2);
    tbl[6]  = mk(N,1,0,0,0,64'hC3,1, 1,0,1,64'hB2,1,2);
    tbl[7]  = mk(N,1,0,0,0,64'hC3,1, 1,0,1,64'hC3,1,2);
    tbl[8]  = mk(N,0,0,0,0,64'h0 ,1, 0,0,0,64'h0 ,1,2);
    tbl[9]  = mk(N,1,0,0,1,64'h30,0, 1,1,1,64'h30,1,2);
    tbl[10] = mk(N,1,1,1,0,64'h40,1, 1,0,1,64'h40,1,2);
    tbl[11] = mk(N,1,1,0,0,64'h50,1, 1,1,1,64'h50,1,2);
    tbl[12] = mk(N,0,0,0,0,64'h0 ,1, 0,0,0,64'h0 ,1,2);
    tbl[13] = mk(N,1,0,0,0,64'h61,0, 1,0,1,64'h61,1,2);
    tbl[14] = mk(N,1,0,0,0,64'h62,0, 2,0,1,64'h61,0,3);
    tbl[15] = mk(R,1,0,0,0,64'h63,0, 2,0,1,64'h61,0,4);
    tbl[16] = mk(R,1,0,0,0,64'h63,0, 2,0,1,64'h61,0,5);
    tbl[17] = mk(R,1,0,0,0,64'h63,0, 2,0,1,64'h61,0,6);
    tbl[18] = mk(O,1,0,0,0,64'h63,1, 2,1,1,64'h61,0,6);
    tbl[19] = mk(N,0,0,0,0,64'h0 ,1, 1,0,1,64'h62,1,6);
    tbl[20] = mk(N,1,0,0,0,64'h64,0, 2,0,1,64'h62,0,7);
    tbl[21] = mk(F,1,0,0,0,64'h65,0, 0,0,1,64'h0 ,0,8);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].hc, tbl[i].uv, tbl[i].unop, tbl[i].ign, tbl[i].sq, tbl[i].ud, tbl[i].dr);
      step();
      chk($sformatf("t%0d_occ", i), 64'(occ), 64'(tbl[i].occ));
      chk($sformatf("t%0d_dv", i), 64'(dv), 64'(tbl[i].occ != 2'd0));
      chk($sformatf("t%0d_ur", i), 64'(ur), 64'(tbl[i].ur));
      chk($sformatf("t%0d_stall", i), 64'(stall), 64'(tbl[i].stall));
      if (tbl[i].chk_nop) chk($sformatf("t%0d_nop", i), 64'(dnop), 64'(tbl[i].nop));
      if (tbl[i].occ != 2'd0) chk($sformatf("t%0d_data", i), dd, tbl[i].data);
    end

    // asynchronous reset while two entries are held
    drive(N, 1, 0, 0, 1, 64'h71, 0);
    step();
    drive(N, 1, 0, 0, 0, 64'h72, 0);
    step();
    chk("pre_rst_occ", 64'(occ), 64'd2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_occ", 64'(occ), 64'd0);
    chk("arst_dv", 64'(dv), 64'd0);
    chk("arst_nop", 64'(dnop), 64'd0);
    chk("arst_data", dd, 64'd0);
    chk("arst_ur", 64'(ur), 64'd0);
    chk("arst_stall", 64'(stall), 64'd0);
    step();
    chk("arst_hold_occ", 64'(occ), 64'd0);
    rst = 1'b0;
    drive(N, 0, 0, 0, 0, 64'h0, 1);
    step();
    chk("post_rst_occ", 64'(occ), 64'd0);
    chk("post_rst_ur", 64'(ur), 64'd1);
    chk("post_rst_stall", 64'(stall), 64'd0);

    // randomized traffic against a queue model
    mcnt = 0;
    mq.delete();
    for (int i = 0; i < 400; i++) begin
      int x;
      x = $urandom_range(0, 9);
      drive((x < 6) ? N : (x == 6) ? O : (x < 9) ? R : F,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
      @(posedge clk);
      sz = mq.size();
      if (hc == R || (sz > 0 && !dr)) mcnt = (mcnt < 65535) ? mcnt + 1 : mcnt;
      if (hc == F) begin
        mq.delete();
      end else if (hc == O) begin
        if (sz > 0) begin
          e = mq[0];
          e.nop = 1'b1;
          mq[0] = e;
        end
      end else if (hc == N) begin
        acc = uv && (sz < 2);
        deq = (sz > 0) && dr;
        if (deq) void'(mq.pop_front());
        if (acc) begin
          e.nop = sq | (unop & ~ign);
          e.d   = ud;
          mq.push_back(e);
        end
      end
      #1;
      chk("rnd_occ", 64'(occ), 64'(mq.size()));
      chk("rnd_dv", 64'(dv), 64'(mq.size() > 0));
      chk("rnd_ur", 64'(ur), 64'((mq.size() < 2) && (hc == N)));
      chk("rnd_stall", 64'(stall), 64'(mcnt));
      if (mq.size() > 0) begin
        chk("rnd_data", dd, mq[0].d);
        chk("rnd_nop", 64'(dnop), 64'(mq[0].nop));
      end
    end

    // saturation of a 2-bit stall counter
    chk("sat_start", 64'(s_stall), 64'd0);
    s_hc = R;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("sat_%0d", k), 64'(s_stall), 64'((k < 3) ? k : 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width (pc plus instruction for the if/id stage).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port hazard_control  input  HAZD_CTL_WIDTH(2)  next-state command from hazard_unit.
REQ-006 SHALL have port ignore_no_op  input  1  ignore the upstream no_op flag on accept.
REQ-007 SHALL have port squash  input  1  prediction failed (pc_offset | pc_overload); marks the accepted entry no_op.
REQ-008 SHALL have port up_valid  input  1  upstream entry present.
REQ-009 SHALL have port up_no_op  input  1  upstream entry is a bubble.
REQ-010 SHALL have port up_data  input  DATA_W  upstream payload.
REQ-011 SHALL have port up_ready  output  1  stage can accept this cycle.
REQ-012 SHALL have port dn_valid  output  1  head entry present.
REQ-013 SHALL have port dn_no_op  output  1  head entry is a bubble.
REQ-014 SHALL have port dn_data  output  DATA_W  head payload.
REQ-015 SHALL have port dn_ready  input  1  downstream consumes the head.
REQ-016 SHALL have port occupancy  output  2  entries held (0..2).
REQ-017 SHALL have port stall_cnt  output  CNT_W  saturating stall-cycle count.

Function
REQ-018 SHALL hold at most two entries (head, skid) of {no_op, data}, kept in FIFO order; no combinational path from up_data to dn_data.
REQ-019 SHALL implement states EMPTY, ONE and TWO; occupancy SHALL equal 0, 1 and 2 respectively.
REQ-020 SHALL drive up_ready = ~rst & (state != TWO) & (hazard_control == NORMAL); accept = up_valid & up_ready.
REQ-021 SHALL drive dn_valid = (state != EMPTY); dequeue = dn_valid & dn_ready & (hazard_control == NORMAL).
REQ-022 SHALL store an accepted entry with no_op = squash | (up_no_op & ~ignore_no_op) and data = up_data.
REQ-023 SHALL, in NORMAL, apply these transitions:
- EMPTY + accept -> ONE.
- ONE + accept & dequeue -> ONE, with the new entry at the head.
- ONE + accept only -> TWO, with the new entry in skid.
- ONE + dequeue only -> EMPTY.
- TWO + dequeue -> ONE, with skid moving to the head.
- All other cases hold.
REQ-024 SHALL, on NO_OP, set the head no_op to 1 if the head is valid, and hold all data and state.
REQ-025 SHALL, on RETRY, hold all entries and state unchanged.
REQ-026 SHALL, on FLUSH, go to EMPTY next cycle, discard both entries, and clear the head no_op; FLUSH has priority over all other events.
REQ-027 SHALL increment stall_cnt each cycle where (hazard_control == RETRY) or (dn_valid & ~dn_ready), saturating at 2^CNT_W-1.
REQ-028 SHALL hold the stale data of invalid entries; downstream qualifies data with dn_valid.

Reset
REQ-029 SHALL, on rst assertion and regardless of clk, set state EMPTY, dn_no_op 0, dn_data 0, skid contents 0, and stall_cnt 0.
REQ-030 SHALL, on reset mid-operation, lose all held entries with no partial transfer; up_ready SHALL be 0 while rst is high.
REQ-031 SHALL have normal operation start on the first clk edge after rst deasserts.

Structure
REQ-032 SHALL take HAZD_CTL_WIDTH and the encodings HAZD_CTL_NORMAL=0, HAZD_CTL_NO_OP=1, HAZD_CTL_RETRY=2 and HAZD_CTL_FLUSH=3 (new) from the shared definitions file.
REQ-033 SHALL keep the EMPTY/ONE/TWO state encodings local to the module.
REQ-034 SHALL place the saturating counter in one sub-module, sat_counter (parameter CNT_W; inputs clk, rst, inc; output count).

Verification
REQ-035 SHALL verify basic flow: NORMAL, dn_ready=1, up_valid=1 with data 0x10, 0x20 on consecutive cycles -> the same values appear on dn_data one cycle later each, and occupancy stays 1.
REQ-036 SHALL verify backpressure: dn_ready=0 and three offers A, B, C -> A at the head, B in skid, occupancy 2, up_ready=0, and C not accepted; then dn_ready=1 -> A, B, C delivered in order.
REQ-037 SHALL verify no_op generation: squash=1 on accept of 0x30 -> dn_no_op=1; up_no_op=1 with ignore_no_op=1 -> dn_no_op=0.
REQ-038 SHALL verify hazard commands: occupancy 2, RETRY for 3 cycles -> state unchanged and stall_cnt +3; NO_OP -> dn_no_op=1 with dn_data unchanged; FLUSH -> occupancy 0 and dn_valid=0 next cycle.
REQ-039 SHALL verify reset and saturation: rst pulsed between clk edges while occupancy is 2 -> all outputs 0 immediately; with CNT_W=2, 5 stall cycles -> stall_cnt=3.
